// File: rtl/demux16_scan_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux16_pkg
// Brief    : Shared widths and FSM state encoding for the demux16 scan scheduler
// Revision : 1.0 - initial release
// ============================================================================
package demux16_pkg;

  localparam int NCH  = 16;
  localparam int SELW = 4;
  localparam int CNTW = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/demux16_scan_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : demux16_scan_sched_if
// Brief    : Control and demux-drive signals between CSR logic and the scheduler
// Revision : 1.0 - initial release
// ============================================================================
interface demux16_scan_sched_if;
  import demux16_pkg::*;

  logic            start;
  logic            abort;
  logic [NCH-1:0]  mask;
  logic [SELW-1:0] sel;
  logic            en_n;
  logic            busy;
  logic            done;

  modport master (
    output start, abort, mask,
    input  sel, en_n, busy, done
  );

  modport slave (
    input  start, abort, mask,
    output sel, en_n, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/demux16_scan_sched_next_ch.sv
`default_nettype none
// ============================================================================
// Module   : demux16_next_ch
// Brief    : Finds the lowest set mask bit, or the lowest set bit above cur
// Revision : 1.0 - initial release
// ============================================================================
module demux16_next_ch
  import demux16_pkg::*;
(
  input  logic [NCH-1:0]  mask_i,
  input  logic [SELW-1:0] cur_i,
  input  logic            first_i,
  output logic [SELW-1:0] nxt_o,
  output logic            found_o
);

  // Scan downward so the last hit taken is the lowest qualifying bit.
  always_comb begin
    nxt_o   = '0;
    found_o = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask_i[i] && (first_i || (SELW'(i) > cur_i))) begin
        nxt_o   = SELW'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/demux16_scan_sched.sv
`default_nettype none
// ============================================================================
// Module   : demux16_scan_sched
// Brief    : Scan scheduler driving demux1_16 select/enable over a channel mask.
//            DEMUX16_SCAN_CONT_EN selects continuous (wrapping) scan.
// Revision : 1.0 - initial release
// ============================================================================
module demux16_scan_sched
  import demux16_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int GAP   = 1
)(
  input  logic               clk,
  input  logic               rst,
  demux16_scan_sched_if.slave bus_if
);

  localparam logic [CNTW-1:0] DWELL_LD = CNTW'(DWELL - 1);
  localparam logic [CNTW-1:0] GAP_LD   = CNTW'((GAP > 0) ? GAP - 1 : 0);

  state_e          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic            en_n_q, en_n_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]  mask_q, mask_d;

  logic            lk_first;
  logic [NCH-1:0]  lk_mask;
  logic [SELW-1:0] nxt;
  logic            found;
  logic            has_next;
  logic [SELW-1:0] nsel;

  // In IDLE the lookup sees the live mask for the start decision; otherwise the frozen copy.
  assign lk_first = (state_q == S_IDLE);
  assign lk_mask  = lk_first ? bus_if.mask : mask_q;

  demux16_next_ch u_next_ch (
    .mask_i  (lk_mask),
    .cur_i   (sel_q),
    .first_i (lk_first),
    .nxt_o   (nxt),
    .found_o (found)
  );

`ifdef DEMUX16_SCAN_CONT_EN
  logic [SELW-1:0] first_q, first_d;
  assign has_next = 1'b1;
  assign nsel     = found ? nxt : first_q;
`else
  assign has_next = found;
  assign nsel     = nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      en_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      mask_q  <= '0;
`ifdef DEMUX16_SCAN_CONT_EN
      first_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_n_q  <= en_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
`ifdef DEMUX16_SCAN_CONT_EN
      first_q <= first_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    en_n_d  = en_n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
`ifdef DEMUX16_SCAN_CONT_EN
    first_d = first_q;
`endif
    if (bus_if.abort) begin
      state_d = S_IDLE;
      en_n_d  = 1'b1;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus_if.start) begin
            if (found) begin
              state_d = S_DRIVE;
              mask_d  = bus_if.mask;
              sel_d   = nxt;
              en_n_d  = 1'b0;
              busy_d  = 1'b1;
              cnt_d   = DWELL_LD;
`ifdef DEMUX16_SCAN_CONT_EN
              first_d = nxt;
`endif
            end else begin
              done_d = 1'b1;
            end
          end
        end
        S_DRIVE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (!has_next) begin
            state_d = S_IDLE;
            en_n_d  = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (GAP > 0) begin
            state_d = S_GAP;
            en_n_d  = 1'b1;
            cnt_d   = GAP_LD;
          end else begin
            sel_d = nsel;
            cnt_d = DWELL_LD;
          end
        end
        S_GAP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            state_d = S_DRIVE;
            sel_d   = nsel;
            en_n_d  = 1'b0;
            cnt_d   = DWELL_LD;
          end
        end
        default: begin
          state_d = S_IDLE;
          en_n_d  = 1'b1;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign bus_if.sel  = sel_q;
  assign bus_if.en_n = en_n_q;
  assign bus_if.busy = busy_q;
  assign bus_if.done = done_q;

endmodule
`default_nettype wire
